// File: rtl/fixedpoint_pkg.sv
// Shared constants and state encoding for the Q4.4 fixed-point arithmetic units.
// Used by fixedpoint_div_s and fixedpoint_sgnmag.
package fixedpoint_pkg;

    localparam int FRAC_W = 4;
    localparam int QW     = 8 + FRAC_W;
    localparam int ITER   = QW;
    localparam int CNT_W  = $clog2(ITER);

    localparam logic [7:0] Q_MAX = 8'h7F;
    localparam logic [7:0] Q_MIN = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/fixedpoint_sgnmag.sv
// Signed 8-bit to sign/magnitude conversion; 0x80 maps to magnitude 128.
// Shared by the divider and the multiplier.
module fixedpoint_sgnmag
    import fixedpoint_pkg::*;
(
    input  logic [7:0] a_i,
    output logic       sign_o,
    output logic [7:0] mag_o
);

    // Two's complement negate when negative; -0x80 wraps to 0x80 = 128 unsigned
    always_comb begin
        sign_o = a_i[7];
        mag_o  = a_i[7] ? (8'd0 - a_i) : a_i;
    end

endmodule

// File: rtl/fixedpoint_div_s.sv
// Sequential signed Q4.4 divider, restoring sign-magnitude, 13-cycle latency.
// Build option: FIXEDPOINT_DIV_SAT_EN saturates out on overflow, else wraps.
module fixedpoint_div_s
    import fixedpoint_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic       busy,
    output logic       done,
    output logic [7:0] out,
    output logic       div_zero,
    output logic       ovf
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rem_q, rem_d;
    logic [QW-1:0]     dvd_q, dvd_d;
    logic [7:0]        dvs_q, dvs_d;
    logic              sgn_q, sgn_d;
    logic              sgn1_q, sgn1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        out_q, out_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    logic              s1, s2;
    logic [7:0]        m1, m2;
    logic [8:0]        rem_sh;
    logic              ge;
    logic              rnd;
    logic [12:0]       mag;
    logic              neg;
    logic              ovf_c;
    logic [7:0]        res;

    fixedpoint_sgnmag u_sm1 (
        .a_i    (in1),
        .sign_o (s1),
        .mag_o  (m1)
    );

    fixedpoint_sgnmag u_sm2 (
        .a_i    (in2),
        .sign_o (s2),
        .mag_o  (m2)
    );

    // State and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            sgn1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            sgn1_q  <= sgn1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, restoring step and result fix-up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        sgn1_d  = sgn1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        // Dividend bits leave the top of dvd_q as quotient bits enter below,
        // so after ITER steps dvd_q holds the full quotient.
        rem_sh  = {rem_q, dvd_q[QW-1]};
        ge      = rem_sh >= {1'b0, dvs_q};

        rnd     = {rem_q, 1'b0} >= {1'b0, dvs_q};
        mag     = {1'b0, dvd_q} + {12'd0, rnd};
        neg     = sgn_q && (mag != 13'd0);
        ovf_c   = neg ? (mag > 13'd128) : (mag > 13'd127);
        res     = neg ? (8'd0 - mag[7:0]) : mag[7:0];
`ifdef FIXEDPOINT_DIV_SAT_EN
        if (ovf_c) begin
            res = neg ? Q_MIN : Q_MAX;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_d   = s1 ^ s2;
                    sgn1_d  = s1;
                    dvd_d   = {m1, {FRAC_W{1'b0}}};
                    dvs_d   = m2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (ge) begin
                    rem_d = 8'(rem_sh - {1'b0, dvs_q});
                end else begin
                    rem_d = rem_sh[7:0];
                end
                dvd_d = {dvd_q[QW-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dvs_q == 8'd0) begin
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                    out_d = sgn1_q ? Q_MIN : Q_MAX;
                end else begin
                    dz_d  = 1'b0;
                    ovf_d = ovf_c;
                    out_d = res;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign div_zero = dz_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fixedpoint_div_s.sv
// Directed testbench for fixedpoint_div_s (Q4.4 signed divider).
// Expected values are hand-computed; overflow outputs depend on FIXEDPOINT_DIV_SAT_EN.
module tb_fixedpoint_div_s;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       div_zero;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    fixedpoint_div_s dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one operation and wait (bounded) for done; lat = edges after the start edge
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] o, output logic dz,
                         output logic ov, output int lat);
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        o  = out;
        dz = div_zero;
        ov = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in1 = 8'h00;
        in2 = 8'h00;
        #2;
        checks++;
        if ({busy, done, out, div_zero, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h dz=%b ovf=%b, want all 0",
                     busy, done, out, div_zero, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int bcnt;
        int lat;
        @(negedge clk);
        in1 = 8'h18;
        in2 = 8'h08;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 13", lat);
        end
        checks++;
        if (bcnt !== 13) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 13", bcnt);
        end
        checks++;
        if ({out, ovf, div_zero, busy} !== {8'h30, 3'b000}) begin
            errors++;
            $display("FAIL basic_result: got out=%h ovf=%b dz=%b busy=%b, want 30 0 0 0",
                     out, ovf, div_zero, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b, want 0", done);
        end
    endtask

    task automatic test_rounding();
        logic [7:0] va [4] = '{8'hE0, 8'h03, 8'hFD, 8'h01};
        logic [7:0] vb [4] = '{8'h30, 8'h20, 8'h20, 8'h02};
        logic [7:0] ve [4] = '{8'hF5, 8'h02, 8'hFE, 8'h08};
        logic [7:0] o;
        logic dz, ov;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], o, dz, ov, lat);
            checks++;
            if ({o, dz, ov} !== {ve[i], 2'b00} || lat !== 13) begin
                errors++;
                $display("FAIL round_%0d: %h/%h got out=%h dz=%b ovf=%b lat=%0d, want %h 0 0 13",
                         i, va[i], vb[i], o, dz, ov, lat, ve[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [3] = '{8'h80, 8'h70, 8'h80};
        logic [7:0] vb [3] = '{8'h10, 8'h08, 8'hF0};
        logic       vo [3] = '{1'b0, 1'b1, 1'b1};
`ifdef FIXEDPOINT_DIV_SAT_EN
        logic [7:0] ve [3] = '{8'h80, 8'h7F, 8'h7F};
`else
        logic [7:0] ve [3] = '{8'h80, 8'hE0, 8'h80};
`endif
        logic [7:0] o;
        logic dz, ov;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], o, dz, ov, lat);
            checks++;
            if ({o, dz, ov} !== {ve[i], 1'b0, vo[i]}) begin
                errors++;
                $display("FAIL bound_%0d: %h/%h got out=%h dz=%b ovf=%b, want %h 0 %b",
                         i, va[i], vb[i], o, dz, ov, ve[i], vo[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] va [3] = '{8'h10, 8'hF0, 8'h00};
        logic [7:0] ve [3] = '{8'h7F, 8'h80, 8'h7F};
        logic [7:0] o;
        logic dz, ov;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], 8'h00, o, dz, ov, lat);
            checks++;
            if ({o, dz, ov} !== {ve[i], 2'b10} || lat !== 13) begin
                errors++;
                $display("FAIL divzero_%0d: %h/00 got out=%h dz=%b ovf=%b lat=%0d, want %h 1 0 13",
                         i, va[i], o, dz, ov, lat, ve[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat;
        int nd;
        int d1;
        int d2;
        // Restart attempt during DIV with new operands must be ignored
        @(negedge clk);
        in1 = 8'h18;
        in2 = 8'h08;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin
                @(negedge clk);
                in1 = 8'h70;
                in2 = 8'h01;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                i++;
                #5;
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (out !== 8'h30 || lat !== 13) begin
            errors++;
            $display("FAIL ignore_start: got out=%h lat=%0d, want 30 13", out, lat);
        end
        // start held high: back-to-back results every 14 cycles
        @(negedge clk);
        in1 = 8'hE0;
        in2 = 8'h30;
        start = 1'b1;
        @(posedge clk);
        #1;
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int i = 1; i <= 27; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (nd !== 2 || d1 !== 13 || d2 !== 27) begin
            errors++;
            $display("FAIL back_to_back: got pulses=%0d at %0d,%0d, want 2 at 13,27",
                     nd, d1, d2);
        end
        checks++;
        if (out !== 8'hF5) begin
            errors++;
            $display("FAIL back_to_back_out: got %h, want F5", out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] o;
        logic dz, ov;
        int lat;
        int nd;
        @(negedge clk);
        in1 = 8'h18;
        in2 = 8'h08;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, out, div_zero, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b done=%b out=%h dz=%b ovf=%b, want all 0",
                     busy, done, out, div_zero, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d pulses, want 0", nd);
        end
        do_op(8'hE0, 8'h30, o, dz, ov, lat);
        checks++;
        if ({o, dz, ov} !== {8'hF5, 2'b00} || lat !== 13) begin
            errors++;
            $display("FAIL reset_mid_restart: got out=%h dz=%b ovf=%b lat=%0d, want F5 0 0 13",
                     o, dz, ov, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_boundaries();
        test_div_zero();
        test_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
